// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the shared data-memory port.
// Each granted transfer runs IDLE -> ACCESS -> RESP and returns registered rdata/err with a one-cycle ack.
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m0_req,
    input  logic                m0_wr,
    input  logic [31:0]         m0_addr,
    input  logic [31:0]         m0_wdata,
    output logic                m0_ack,
    output logic [31:0]         m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic                m1_wr,
    input  logic [31:0]         m1_addr,
    input  logic [31:0]         m1_wdata,
    output logic                m1_ack,
    output logic [31:0]         m1_rdata,
    output logic                m1_err,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_acc,
    output logic                busy,
    output logic                gnt_id,
    output logic [ERRCNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                gnt_id_q, gnt_id_d;
    logic                wr_q, wr_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0][31:0]    rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [1:0] req;
    logic       win;

    assign req = {m1_req, m0_req};

    // On a tie the master that did not win last time goes first, unless M0 has fixed priority.
    always_comb begin
        win = m1_req;
        if (req == 2'b11)
            win = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_id_d   = gnt_id_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        ack_d      = 2'b00;
        rdata_d    = rdata_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = ACCESS;
                    gnt_id_d   = win;
                    last_gnt_d = win;
                    wr_d       = win ? m1_wr : m0_wr;
                    addr_d     = win ? m1_addr : m0_addr;
                    wdata_d    = win ? m1_wdata : m0_wdata;
                    mem_rd_d   = ~wr_d;
                    mem_wr_d   = wr_d;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!wr_q)
                    rdata_d[gnt_id_q] = mem_rdata;
                err_d[gnt_id_q] = ~mem_acc;
                ack_d[gnt_id_q] = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                if (err_q[gnt_id_q] && !(&err_cnt_q))
                    err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset clears the write strobe immediately so an in-flight write never commits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_id_q   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_id_q   <= gnt_id_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign gnt_id    = gnt_id_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: transaction-level reference model plus decoupled monitor,
// followed by directed saturation, reset-mid-write and fixed-priority scenarios.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_v = 2'b00;
    logic [1:0]  wr_v = 2'b00;
    logic [31:0] addr_v [2] = '{default: 32'h0};
    logic [31:0] wdata_v [2] = '{default: 32'h0};

    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_rd, mem_wr, mem_acc, busy, gnt_id;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  err_cnt;
    logic [1:0]  ack_v;
    assign ack_v = {m1_ack, m0_ack};

    // Environment memory: 16 words at 0x1000..0x103f, word-aligned only.
    logic [31:0] tb_mem [16] = '{default: 32'h0};
    assign mem_acc   = (mem_addr[31:6] == 26'h40) && (mem_addr[1:0] == 2'b00);
    assign mem_rdata = tb_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_wr && mem_acc) tb_mem[mem_addr[5:2]] <= mem_wdata;

    dmem_arbiter #(.FIXED_PRIO(1'b0), .ERRCNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req_v[0]), .m0_wr(wr_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(req_v[1]), .m1_wr(wr_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_acc(mem_acc),
        .busy(busy), .gnt_id(gnt_id), .err_cnt(err_cnt)
    );

    // Second instance for the fixed-priority scenario.
    logic [1:0]  fp_req = 2'b00;
    logic        fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
    logic        fp_mem_rd, fp_mem_wr, fp_busy, fp_gnt_id;
    logic [7:0]  fp_err_cnt;

    dmem_arbiter #(.FIXED_PRIO(1'b1), .ERRCNT_W(8)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_req(fp_req[0]), .m0_wr(1'b0), .m0_addr(32'h1000), .m0_wdata(32'h0),
        .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
        .m1_req(fp_req[1]), .m1_wr(1'b0), .m1_addr(32'h1004), .m1_wdata(32'h0),
        .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
        .mem_rd(fp_mem_rd), .mem_wr(fp_mem_wr), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_rdata(32'h0), .mem_acc(1'b1),
        .busy(fp_busy), .gnt_id(fp_gnt_id), .err_cnt(fp_err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    typedef struct { int cyc; logic [31:0] rdata; logic err; } resp_t;
    typedef struct { int cyc; logic wr; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    resp_t exp_q0 [$];
    resp_t exp_q1 [$];
    acc_t  acc_q [$];

    // Reference model state: serialized memory image, tie-break history, per-master last read data.
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    logic        last_m = 1'b1;
    int          free_at = 0;
    logic [31:0] last_rd [2] = '{default: 32'h0};
    int          exp_cnt = 0;
    logic        mon_en = 1'b0;
    logic        gen_new = 1'b0;
    logic        err_mode = 1'b0;

    function automatic logic [31:0] rand_addr(input logic emode);
        int unsigned r = $urandom_range(0, 7);
        logic [31:0] w = 32'h1000 + ($urandom_range(0, 15) << 2);
        if (emode) return 32'h3;
        if (r == 0) return w + 32'h1000;
        if (r == 1) return w | 32'h2;
        return w;
    endfunction

    function automatic logic acc_ok(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h1040) && (a % 4 == 0);
    endfunction

    // One negedge step: masters retire/issue commands, then the model grants if the port is free.
    task automatic rand_cycle();
        logic  w;
        resp_t e;
        acc_t  a;
        for (int m = 0; m < 2; m++) begin
            if (req_v[m] && ack_v[m]) req_v[m] = 1'b0;
            if (!req_v[m] && gen_new && $urandom_range(0, 2) != 0) begin
                req_v[m]   = 1'b1;
                wr_v[m]    = 1'($urandom_range(0, 1));
                addr_v[m]  = rand_addr(err_mode);
                wdata_v[m] = $urandom;
            end
        end
        if (cyc >= free_at && req_v != 2'b00) begin
            if (req_v == 2'b11) w = ~last_m;
            else w = req_v[1];
            last_m  = w;
            free_at = cyc + 3;
            a.cyc = cyc + 1; a.wr = wr_v[w]; a.addr = addr_v[w]; a.wdata = wdata_v[w];
            acc_q.push_back(a);
            if (!wr_v[w]) last_rd[w] = ref_mem[addr_v[w][5:2]];
            else if (acc_ok(addr_v[w])) ref_mem[addr_v[w][5:2]] = wdata_v[w];
            e.cyc = cyc + 2; e.rdata = last_rd[w]; e.err = !acc_ok(addr_v[w]);
            if (w) exp_q1.push_back(e);
            else exp_q0.push_back(e);
        end
    endtask

    task automatic drain();
        gen_new = 1'b0;
        for (int i = 0; i < 100 && !(req_v == 2'b00 && exp_q0.size() == 0 && exp_q1.size() == 0); i++) begin
            @(negedge clk);
            rand_cycle();
        end
        if (req_v != 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares every DUT cycle against what the model queued.
    initial begin
        resp_t e;
        acc_t  a;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("ack_both", 32'(m0_ack & m1_ack), 32'h0);
                chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
                while (exp_q0.size() > 0 && exp_q0[0].cyc < cyc) begin void'(exp_q0.pop_front()); fail("m0_missing_ack"); end
                while (exp_q1.size() > 0 && exp_q1[0].cyc < cyc) begin void'(exp_q1.pop_front()); fail("m1_missing_ack"); end
                while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin void'(acc_q.pop_front()); fail("missing_access"); end
                if (m0_ack) begin
                    if (exp_q0.size() == 0) fail("m0_unexpected_ack");
                    else begin
                        e = exp_q0.pop_front();
                        chk("m0_ack_cycle", 32'(cyc), 32'(e.cyc));
                        chk("m0_rdata", m0_rdata, e.rdata);
                        chk("m0_err", 32'(m0_err), 32'(e.err));
                        chk("gnt_id_m0", 32'(gnt_id), 32'h0);
                        chk("busy_resp", 32'(busy), 32'h1);
                        if (e.err && exp_cnt < 255) exp_cnt++;
                    end
                end
                if (m1_ack) begin
                    if (exp_q1.size() == 0) fail("m1_unexpected_ack");
                    else begin
                        e = exp_q1.pop_front();
                        chk("m1_ack_cycle", 32'(cyc), 32'(e.cyc));
                        chk("m1_rdata", m1_rdata, e.rdata);
                        chk("m1_err", 32'(m1_err), 32'(e.err));
                        chk("gnt_id_m1", 32'(gnt_id), 32'h1);
                        chk("busy_resp", 32'(busy), 32'h1);
                        if (e.err && exp_cnt < 255) exp_cnt++;
                    end
                end
                if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
                    a = acc_q.pop_front();
                    chk("mem_rd_access", 32'(mem_rd), 32'(!a.wr));
                    chk("mem_wr_access", 32'(mem_wr), 32'(a.wr));
                    chk("mem_addr", mem_addr, a.addr);
                    if (a.wr) chk("mem_wdata", mem_wdata, a.wdata);
                    chk("busy_access", 32'(busy), 32'h1);
                end else begin
                    chk("mem_rd_idle", 32'(mem_rd), 32'h0);
                    chk("mem_wr_idle", 32'(mem_wr), 32'h0);
                end
            end
        end
    end

    initial begin
        #400000;
        fail("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] saved;
        int n0, n1, m1_after;

        // Reset values while reset is held.
        #3;
        chk("rst_ack", 32'({m1_ack, m0_ack}), 32'h0);
        chk("rst_err", 32'({m1_err, m0_err}), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_mem_strobes", 32'({mem_rd, mem_wr}), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        free_at = cyc;
        mon_en  = 1'b1;

        // Mixed random traffic: reads, writes, unmapped and unaligned addresses.
        gen_new = 1'b1;
        repeat (1500) begin @(negedge clk); rand_cycle(); end
        drain();

        // Error-only traffic long enough to saturate the 8-bit counter.
        err_mode = 1'b1;
        gen_new  = 1'b1;
        repeat (1000) begin @(negedge clk); rand_cycle(); end
        drain();
        chk("err_cnt_saturated", 32'(err_cnt), 32'd255);
        mon_en = 1'b0;

        // Reset asserted during ACCESS of an M1 write.
        @(negedge clk);
        saved      = tb_mem[5];
        req_v      = 2'b10;
        wr_v[1]    = 1'b1;
        addr_v[1]  = 32'h1014;
        wdata_v[1] = ~saved;
        @(posedge clk);
        #2;
        chk("rstw_mem_wr_in_access", 32'(mem_wr), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstw_mem_wr_async_drop", 32'(mem_wr), 32'h0);
        @(negedge clk);
        req_v = 2'b00;
        @(negedge clk);
        chk("rstw_no_ack_in_reset", 32'(m1_ack), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstw_no_ack_after", 32'({m1_ack, m0_ack}), 32'h0);
        end
        chk("rstw_mem_unchanged", tb_mem[5], saved);
        chk("rstw_err_cnt", 32'(err_cnt), 32'h0);
        chk("rstw_gnt_id", 32'(gnt_id), 32'h0);
        chk("rstw_busy", 32'(busy), 32'h0);
        chk("rstw_m0_rdata", m0_rdata, 32'h0);
        chk("rstw_m1_err", 32'(m1_err), 32'h0);
        chk("rstw_mem_addr", mem_addr, 32'h0);
        chk("rstw_mem_wdata", mem_wdata, 32'h0);

        // Fixed priority: M0 holds req for three transfers, M1 must wait until it drops.
        n0 = 0; n1 = 0; m1_after = -1;
        @(negedge clk);
        fp_req = 2'b11;
        for (int i = 0; i < 60 && n1 == 0; i++) begin
            @(negedge clk);
            if (fp_m0_ack) begin
                n0++;
                if (n0 == 3) fp_req[0] = 1'b0;
            end
            if (fp_m1_ack) begin
                n1++;
                m1_after = n0;
                fp_req[1] = 1'b0;
            end
        end
        chk("fp_m0_grants", 32'(n0), 32'd3);
        chk("fp_m1_grants", 32'(n1), 32'd1);
        chk("fp_m1_after_m0_drop", 32'(m1_after), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single data-memory port. The CPU load/store unit (master 0) and a secondary bus master such as a debug/UART loader or DMA (master 1) share one `rd`/`wr`/`addr`/`wdata`/`rdata`/accessible memory port, which also reaches the peripheral window. The arbiter grants the port round-robin, latches the winner's command, and runs one memory access. It then returns registered read data and an error flag to the winner with a one-cycle `ack` pulse.

## Interface
- `FIXED_PRIO`, default 0: 1 makes master 0 always win a simultaneous request; 0 selects round-robin.
- `ERRCNT_W`, default 8: width of the saturating access-error counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `m0_req` / `m1_req`  in  1  request. Held high, with that master's `wr`/`addr`/`wdata` stable, until `ack`.
- `m0_wr` / `m1_wr`  in  1  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  32  byte address, passed unchanged to memory.
- `m0_wdata` / `m1_wdata`  in  32  write data.
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata` / `m1_rdata`  out  32  registered read data; valid while `ack` is high.
- `m0_err` / `m1_err`  out  1  registered; valid while `ack` is high; 1 = memory reported the address not accessible.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  combinational read data from memory.
- `mem_acc`  in  1  combinational accessible flag from memory.
- `busy`  out  1  high in ACCESS and RESP.
- `gnt_id`  out  1  master owning the current or last transfer.
- `err_cnt`  out  `ERRCNT_W`  saturating count of completed transfers with `err`=1.

## Operation
- The FSM has three states, IDLE, ACCESS and RESP:
  - IDLE → ACCESS when any `req` is high.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration happens only in IDLE.
  - With one request, that master wins.
  - With both requests and `FIXED_PRIO`=0, the master other than `last_gnt` wins.
  - With both requests and `FIXED_PRIO`=1, master 0 wins.
  - `last_gnt` resets to 1, so master 0 wins the first tie.
- On the IDLE→ACCESS edge, the winner's `wr`, `addr` and `wdata` are latched into `wr_q`, `addr_q` and `wdata_q`, and `gnt_id`/`last_gnt` are updated.
- In ACCESS, `mem_rd` = ~`wr_q` and `mem_wr` = `wr_q`, both registered. `mem_addr` = `addr_q` and `mem_wdata` = `wdata_q`.
  - A write commits in memory on the edge that ends ACCESS.
  - On that same edge, `mem_rdata` is captured into the winner's `rdata` register (reads only) and ~`mem_acc` into its `err` register.
- Outside ACCESS, `mem_rd` and `mem_wr` are 0; `mem_addr` and `mem_wdata` hold their last values.
- In RESP, only the winner's `ack` is 1.
  - The loser's `ack` stays 0 and its `rdata`/`err` registers are unchanged.
  - `err_cnt` increments at the end of RESP if `err`=1, saturating at all-ones.
- Once granted, a transfer completes even if the master drops `req` mid-transfer; `ack` is still issued.
- A `req` still high in the IDLE cycle after `ack` is a new transfer. Requesters must update the command on the edge where they sample `ack`.
- A request from the losing master stays pending and wins the next IDLE when `FIXED_PRIO`=0.
- An unaligned or unmapped address gets no special handling; it completes with `err`=1, and the memory must ignore the write.

## Timing
- Reset values:
  - State IDLE; `last_gnt`=1; `gnt_id`=0.
  - All `ack` = 0, `err` = 0, `rdata` = 0.
  - `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
  - `busy`=0; `err_cnt`=0.
- Latency: `req` rising in cycle N (state IDLE) gives ACCESS in N+1 and `ack` in N+2.
- Throughput: one transfer per 3 cycles. With both masters continuously requesting under round-robin, grants alternate.
- `ack` is exactly one cycle wide; it is never asserted for both masters, and never for two consecutive cycles.
- Asynchronous reset in ACCESS drops `mem_wr` immediately, so no write commits. No `ack` is issued, and the FSM restarts in IDLE after reset release.
- Reset in RESP cancels the `ack` pulse.

## Test plan
- Single read: after reset, M0 reads 0x10010004, with the memory returning 0xdeadbeef and `mem_acc`=1. Required: `mem_rd`=1 for one cycle, `m0_ack` two cycles after `req`, `m0_rdata`=0xdeadbeef, `m0_err`=0.
- Write then read back: M1 writes 0x12345678 to 0x7ffffffc, then reads it. Required: one-cycle `mem_wr`; readback 0x12345678; `gnt_id`=1 on both transfers.
- Simultaneous round-robin: `m0_req` and `m1_req` held high for 4 transfers with `FIXED_PRIO`=0. Required grant order M0, M1, M0, M1; `ack` at cycles 2, 5, 8, 11.
- Fixed priority: same stimulus with `FIXED_PRIO`=1. Required: M0 granted every time while its `req` stays high, and M1 only after `m0_req` drops.
- Error path: M0 reads 0x00000003 with `mem_acc`=0. Required: `m0_err`=1 on `ack` and `err_cnt` goes 0 → 1. After 300 such errors with `ERRCNT_W`=8, `err_cnt`=255.
- Reset mid-write: `reset_n` asserted during ACCESS of an M1 write. Required: `mem_wr` falls asynchronously, the memory location is unchanged, no `m1_ack`, and all outputs return to reset values.
